mem_arbiter: RTL

- Two-port controller that shares the single 14-bit-address / 10-bit-data memory block between two requesters.
- Port A is instruction fetch (read-only). Port B is data load/store.
- Sequences every access on the memory strobes, covers the extra RAM read-latency cycle, and returns registered read data with a one-cycle ack.
- Sits between the CPU core and the memory block in the top level.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter_rr_pick.sv | 23 ++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Memory map: bit RAM_BIT selects registered-read RAM (1) or combinational, write-protected ROM (0).
package sifo_mem_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned DATA_W  = 10;
  localparam int unsigned RAM_BIT = 13;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } port_id_t;

  // Operands latched from the winning port at grant time
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_op_t;

  function automatic logic is_ram(input logic [ADDR_W-1:0] addr);
    return addr[RAM_BIT];
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus memory block view.
interface mem_arbiter_if;
  import sifo_mem_pkg::*;

  logic              a_req;
  logic [ADDR_W-1:0] a_addr;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata, b_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata, mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata, b_err,
           mem_addr, mem_wdata, mem_write, mem_read
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: on contention the port that
// did not win last time is granted.
module mem_rr_pick
  import sifo_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_id_t   i_last_grant,
  output logic       o_gnt_valid_c,
  output port_id_t   o_gnt_id_c
);

  always_comb begin
    o_gnt_valid_c = |i_req;
    o_gnt_id_c    = PORT_A;
    case (i_req)
      2'b01:   o_gnt_id_c = PORT_A;
      2'b10:   o_gnt_id_c = PORT_B;
      2'b11:   o_gnt_id_c = (i_last_grant == PORT_A) ? PORT_B : PORT_A;
      default: o_gnt_id_c = PORT_A;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory block between an instruction-fetch port (A) and a
// load/store port (B); sequences strobes and returns registered data with a one-cycle ack.
module mem_arbiter
  import sifo_mem_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_t            r_state;
  state_t            w_next_state;
  port_id_t          r_last_grant;
  port_id_t          r_winner;
  mem_op_t           r_op;
  mem_op_t           w_sel_op;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_a_ack;
  logic              r_b_ack;
  logic              r_err_flag;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_gnt_valid;
  port_id_t          w_gnt_id;
  logic              w_load;
  logic              w_capture;
  logic              w_err_set;
  logic              w_a_ack_d;
  logic              w_b_ack_d;
  logic              w_mem_read_d;
  logic              w_mem_write_d;

  mem_rr_pick u_pick (
    .i_req         ({bus.b_req, bus.a_req}),
    .i_last_grant  (r_last_grant),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_id_c    (w_gnt_id)
  );

  // Operands of the port that would win this cycle; port A never writes
  always_comb begin
    w_sel_op = '0;
    if (w_gnt_id == PORT_B) begin
      w_sel_op.we    = bus.b_we;
      w_sel_op.addr  = bus.b_addr;
      w_sel_op.wdata = bus.b_wdata;
    end else begin
      w_sel_op.addr  = bus.a_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Strobes and acks are computed for the next state so they come out of flops
  always_comb begin
    w_next_state  = r_state;
    w_load        = 1'b0;
    w_capture     = 1'b0;
    w_err_set     = 1'b0;
    w_a_ack_d     = 1'b0;
    w_b_ack_d     = 1'b0;
    w_mem_read_d  = 1'b0;
    w_mem_write_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_next_state  = ISSUE;
          w_load        = 1'b1;
          w_mem_read_d  = ~w_sel_op.we;
          w_mem_write_d = w_sel_op.we & is_ram(w_sel_op.addr);
        end
      end
      ISSUE: begin
        if (r_op.we) begin
          w_next_state = ACK;
          w_err_set    = ~is_ram(r_op.addr);
        end else if (is_ram(r_op.addr)) begin
          w_next_state = WAIT;
          w_mem_read_d = 1'b1;
        end else begin
          w_next_state = ACK;
          w_capture    = 1'b1;
        end
      end
      WAIT: begin
        w_next_state = ACK;
        w_capture    = 1'b1;
      end
      ACK:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (w_next_state == ACK) begin
      w_a_ack_d = (r_winner == PORT_A);
      w_b_ack_d = (r_winner == PORT_B);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= PORT_B;
      r_winner     <= PORT_A;
      r_op         <= '0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
      r_a_ack      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_err_flag   <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_a_ack     <= w_a_ack_d;
      r_b_ack     <= w_b_ack_d;
      r_mem_read  <= w_mem_read_d;
      r_mem_write <= w_mem_write_d;
      if (w_load) begin
        r_op         <= w_sel_op;
        r_winner     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      if (w_capture) begin
        if (r_winner == PORT_A) r_a_rdata <= bus.mem_rdata;
        else                    r_b_rdata <= bus.mem_rdata;
      end
      // Only port B can write, so the flag always belongs to B's ack
      if (w_err_set)            r_err_flag <= 1'b1;
      else if (r_state == ACK)  r_err_flag <= 1'b0;
    end
  end

  assign bus.a_ack     = r_a_ack;
  assign bus.a_rdata   = r_a_rdata;
  assign bus.b_ack     = r_b_ack;
  assign bus.b_rdata   = r_b_rdata;
  assign bus.b_err     = r_err_flag;
  assign bus.mem_addr  = r_op.addr;
  assign bus.mem_wdata = r_op.wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;

endmodule
